// File: rtl/sram_sp_bwe_model_pkg.sv
// rtl/sram_sp_bwe_model_pkg.sv - shared types and helpers for the single-port SRAM model
package sram_model_pkg;

  // Array controller state: zero-fill in progress, or open for access
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int MAX_READ_LATENCY = 3;

  // Number of write-mask lanes for a given data width and lane size
  function automatic int lanes(input int bits, input int gran);
    return bits / gran;
  endfunction

endpackage

// File: rtl/sram_sp_bwe_model_if.sv
// rtl/sram_sp_bwe_model_if.sv - access bus between an array wrapper and the SRAM model
interface sram_sp_bwe_model_if
  import sram_model_pkg::*;
#(
  parameter int BITS      = 64,
  parameter int ADD_WIDTH = 10,
  parameter int MASK_GRAN = 8
);

  logic                               CEB;
  logic                               WEB;
  logic [lanes(BITS, MASK_GRAN)-1:0]  BWEB;
  logic [ADD_WIDTH-1:0]               A;
  logic [BITS-1:0]                    D;
  logic [BITS-1:0]                    Q;
  logic                               Q_VALID;
  logic                               INIT_BUSY;
  logic                               ERR;

  // Requester side: drives the access, observes data and status
  modport master (
    output CEB, WEB, BWEB, A, D,
    input  Q, Q_VALID, INIT_BUSY, ERR
  );

  // Memory side
  modport slave (
    input  CEB, WEB, BWEB, A, D,
    output Q, Q_VALID, INIT_BUSY, ERR
  );

endinterface

// File: rtl/sram_sp_bwe_model_rd_pipe.sv
// rtl/sram_sp_bwe_model_rd_pipe.sv - read-latency delay line and Q output register
module sram_rd_pipe #(
  parameter int BITS         = 64,
  parameter int READ_LATENCY = 1,
  parameter int HOLD_Q       = 1
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic [BITS-1:0] Q,
  output logic            Q_VALID
);

  // 32-bit words needed to cover the data width with random fill
  localparam int RW = (BITS + 31) / 32;

  logic [READ_LATENCY-1:0] vld;
  logic [BITS-1:0]         dat [READ_LATENCY];

  // Shift {valid, data} one stage per cycle; stage 0 captures the request edge
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  // Present the completing read; otherwise hold or scribble Q so stale data is obvious
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      Q       <= '0;
      Q_VALID <= 1'b0;
    end else begin
      Q_VALID <= vld[READ_LATENCY-1];
      if (vld[READ_LATENCY-1]) begin
        Q <= dat[READ_LATENCY-1];
      end else if (HOLD_Q == 0) begin
        Q <= BITS'({RW{32'($random)}});
      end
    end
  end

endmodule

// File: rtl/sram_sp_bwe_model.sv
// rtl/sram_sp_bwe_model.sv - parametrised single-port SRAM model with lane masks and zero-fill
module sram_sp_bwe_model
  import sram_model_pkg::*;
#(
  parameter int BITS          = 64,
  parameter int WORD_DEPTH    = 1024,
  parameter int ADD_WIDTH     = 10,
  parameter int MASK_GRAN     = 8,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_ON_RESET = 1,
  parameter int HOLD_Q        = 1
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  sram_sp_bwe_model_if.slave   bus
);

  localparam int LANES = lanes(BITS, MASK_GRAN);
  localparam int IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WORD_DEPTH - 1);
  localparam logic [ADD_WIDTH:0] DEPTH_EXT = (ADD_WIDTH + 1)'(WORD_DEPTH);

  if (BITS % MASK_GRAN != 0) begin : g_bad_gran
    $fatal(1, "sram_sp_bwe_model: BITS must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $fatal(1, "sram_sp_bwe_model: READ_LATENCY must be 1..3");
  end
  if ((2 ** ADD_WIDTH) < WORD_DEPTH) begin : g_bad_addr
    $fatal(1, "sram_sp_bwe_model: ADD_WIDTH too narrow for WORD_DEPTH");
  end

  logic [BITS-1:0] ram [WORD_DEPTH];

  sram_state_e      state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             err, err_n;

  logic             in_range;
  logic [IDX_W-1:0] a_idx;
  logic             rd_fire;
  logic             wr_fire;
  logic [BITS-1:0]  rd_data;

  assign in_range = {1'b0, bus.A} < DEPTH_EXT;
  assign a_idx    = bus.A[IDX_W-1:0];
  assign rd_fire  = (state == READY) && !bus.CEB && bus.WEB;
  assign wr_fire  = (state == READY) && !bus.CEB && !bus.WEB && in_range;
  assign rd_data  = in_range ? ram[a_idx] : '0;

  assign bus.INIT_BUSY = (state == INIT);
  assign bus.ERR       = err;

  // Next state: walk the fill counter, flag accesses during fill or beyond the array
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err;
    if (state == INIT) begin
      cnt_n = cnt + 1'b1;
      if (cnt == LAST_IDX) begin
        state_n = READY;
        cnt_n   = '0;
      end
      if (!bus.CEB) err_n = 1'b1;
    end else begin
      if (!bus.CEB && !in_range) err_n = 1'b1;
    end
  end

  // State, fill counter and sticky error register
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state <= (INIT_ON_RESET != 0) ? INIT : READY;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  // Array update: zero-fill during INIT, lane-masked writes when READY; reset never touches contents
  always_ff @(posedge CLK) begin
    if (RSTB) begin
      if (state == INIT) begin
        ram[cnt] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < LANES; i++) begin
          if (!bus.BWEB[i]) begin
            ram[a_idx][i*MASK_GRAN +: MASK_GRAN] <= bus.D[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end
  end

  sram_rd_pipe #(
    .BITS         (BITS),
    .READ_LATENCY (READ_LATENCY),
    .HOLD_Q       (HOLD_Q)
  ) u_rd_pipe (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .in_valid (rd_fire),
    .in_data  (rd_data),
    .Q        (bus.Q),
    .Q_VALID  (bus.Q_VALID)
  );

endmodule

// File: tb/tb_sram_sp_bwe_model.sv
// tb/tb_sram_sp_bwe_model.sv - directed bench for sram_sp_bwe_model
module tb_sram_sp_bwe_model;

  logic clk;
  logic rstb;

  sram_sp_bwe_model_if #(.BITS(16), .ADD_WIDTH(4), .MASK_GRAN(8)) bus ();

  sram_sp_bwe_model #(
    .BITS          (16),
    .WORD_DEPTH    (12),
    .ADD_WIDTH     (4),
    .MASK_GRAN     (8),
    .READ_LATENCY  (2),
    .INIT_ON_RESET (1),
    .HOLD_Q        (1)
  ) dut (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] bweb);
    bus.CEB = 1'b0; bus.WEB = 1'b0; bus.A = a; bus.D = d; bus.BWEB = bweb;
    cyc();
    bus.CEB = 1'b1; bus.WEB = 1'b1;
  endtask

  // Read with latency check: nothing after one edge, data after exactly two
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    bus.CEB = 1'b0; bus.WEB = 1'b1; bus.A = a; bus.BWEB = 2'b00;
    cyc();
    bus.CEB = 1'b1;
    cyc();
    chk({tag, "_early_vld"}, {31'd0, bus.Q_VALID}, 32'd0);
    cyc();
    chk({tag, "_vld"}, {31'd0, bus.Q_VALID}, 32'd1);
    chk({tag, "_q"}, {16'd0, bus.Q}, {16'd0, exp});
  endtask

  // Count cycles INIT_BUSY stays high, starting just after the last reset edge
  task automatic busy_len(output int n, output int q_bad);
    n = 0;
    q_bad = 0;
    while (bus.INIT_BUSY && n < 40) begin
      if (bus.Q !== 16'h0 || bus.Q_VALID !== 1'b0) q_bad++;
      cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    int q_bad;
    int zero_bad;

    bus.CEB = 1'b1; bus.WEB = 1'b1; bus.BWEB = 2'b00; bus.A = '0; bus.D = '0;
    rstb = 1'b0;
    cyc();
    cyc();
    chk("rst_q", {16'd0, bus.Q}, 32'h0);
    chk("rst_qvld", {31'd0, bus.Q_VALID}, 32'd0);
    chk("rst_err", {31'd0, bus.ERR}, 32'd0);
    chk("rst_busy", {31'd0, bus.INIT_BUSY}, 32'd1);
    rstb = 1'b1;

    busy_len(n, q_bad);
    chk("init_len", n, 32'd12);
    chk("init_q_hold", q_bad, 32'd0);

    zero_bad = 0;
    for (int a = 0; a < 12; a++) begin
      bus.CEB = 1'b0; bus.WEB = 1'b1; bus.A = 4'(a);
      cyc();
      bus.CEB = 1'b1;
      cyc();
      cyc();
      if (bus.Q_VALID !== 1'b1 || bus.Q !== 16'h0) zero_bad++;
    end
    chk("init_zero_reads", zero_bad, 32'd0);
    chk("err_clean", {31'd0, bus.ERR}, 32'd0);

    wr(4'd3, 16'hBEEF, 2'b00);
    rd_chk("beef", 4'd3, 16'hBEEF);

    wr(4'd3, 16'h1234, 2'b10);
    rd_chk("mask_lo", 4'd3, 16'hBE34);
    wr(4'd3, 16'h1234, 2'b01);
    rd_chk("mask_hi", 4'd3, 16'h1234);
    wr(4'd3, 16'hFFFF, 2'b11);
    rd_chk("mask_none", 4'd3, 16'h1234);
    chk("mask_none_err", {31'd0, bus.ERR}, 32'd0);

    wr(4'd0, 16'h000A, 2'b00);
    wr(4'd1, 16'h000B, 2'b00);
    wr(4'd2, 16'h000C, 2'b00);
    bus.CEB = 1'b0; bus.WEB = 1'b1; bus.A = 4'd0; bus.BWEB = 2'b11;
    cyc();
    bus.A = 4'd1;
    cyc();
    bus.A = 4'd2;
    cyc();
    chk("b2b0_vld", {31'd0, bus.Q_VALID}, 32'd1);
    chk("b2b0_q", {16'd0, bus.Q}, 32'h000A);
    bus.WEB = 1'b0; bus.A = 4'd2; bus.D = 16'hDEAD; bus.BWEB = 2'b00;
    cyc();
    bus.CEB = 1'b1; bus.WEB = 1'b1;
    chk("b2b1_vld", {31'd0, bus.Q_VALID}, 32'd1);
    chk("b2b1_q", {16'd0, bus.Q}, 32'h000B);
    cyc();
    chk("b2b2_vld", {31'd0, bus.Q_VALID}, 32'd1);
    chk("b2b2_q", {16'd0, bus.Q}, 32'h000C);
    cyc();
    chk("b2b_end_vld", {31'd0, bus.Q_VALID}, 32'd0);
    chk("b2b_hold_q", {16'd0, bus.Q}, 32'h000C);
    rd_chk("war_landed", 4'd2, 16'hDEAD);

    wr(4'd13, 16'h5555, 2'b00);
    chk("oor_wr_err", {31'd0, bus.ERR}, 32'd1);
    rd_chk("oor_rd", 4'd13, 16'h0000);
    rd_chk("oor_no_alias", 4'd1, 16'h000B);
    cyc();
    cyc();
    chk("err_sticky", {31'd0, bus.ERR}, 32'd1);

    rstb = 1'b0;
    cyc();
    rstb = 1'b1;
    chk("err_cleared", {31'd0, bus.ERR}, 32'd0);
    chk("q_cleared", {16'd0, bus.Q}, 32'h0);
    for (int i = 0; i < 4; i++) cyc();
    bus.CEB = 1'b0; bus.WEB = 1'b0; bus.A = 4'd0; bus.D = 16'hFFFF; bus.BWEB = 2'b00;
    cyc();
    bus.CEB = 1'b1; bus.WEB = 1'b1;
    chk("init_access_err", {31'd0, bus.ERR}, 32'd1);
    busy_len(n, q_bad);
    chk("init_access_len", n, 32'd7);
    rd_chk("init_no_write", 4'd0, 16'h0000);

    rstb = 1'b0;
    cyc();
    rstb = 1'b1;
    q_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Q !== 16'h0) q_bad++;
      cyc();
    end
    chk("pre_restart_busy", {31'd0, bus.INIT_BUSY}, 32'd1);
    rstb = 1'b0;
    cyc();
    rstb = 1'b1;
    busy_len(n, zero_bad);
    chk("restart_len", n, 32'd12);
    chk("restart_q_hold", q_bad + zero_bad, 32'd0);
    chk("restart_err", {31'd0, bus.ERR}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
